ov5640_init_seq: RTL and testbench

Sequencer that walks the OV5640 RGB init register table and writes every entry to the camera over the SCCB master.
- Reads table entries through the table's registered-ROM port (address in, 24-bit {reg_addr[15:0], data[7:0]} out).
- Inserts the power-up delay and the post-software-reset delay.
- Retries NACKed writes.
- Reports busy, done and error to the top level, which gates the camera capture and UDP datapath on init_done.

---
 rtl/ov5640_init_pkg.sv | 27 ++
 rtl/ov5640_delay_cnt.sv | 36 +++
 rtl/ov5640_init_seq.sv | 186 ++++++++++++++++++
 tb/tb_ov5640_init_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_init_pkg.sv
// Shared types and constants for the OV5640 register-table init sequencer.
package ov5640_init_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        FETCH,
        ROMWAIT,
        ISSUE,
        WAITDONE,
        DLY,
        DONE,
        ERROR
    } state_t;

    // Delays for a 50 MHz clock: 20 ms power-up, 5 ms after soft reset
    localparam int PWRUP_DELAY_50M = 1_000_000;
    localparam int RST_DELAY_50M   = 250_000;

    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;
    localparam int DATA_MSB     = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov5640_delay_cnt.sv
// Loadable down-counter; emits a one-cycle expire pulse, zero load costs one cycle.
module ov5640_delay_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;
    logic             running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
            expire  <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (start) begin
                cnt     <= load;
                running <= 1'b1;
            end else if (running) begin
                if (cnt <= WIDTH'(1)) begin
                    running <= 1'b0;
                    expire  <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ov5640_init_seq.sv
// Walks the OV5640 init table and writes each entry through the SCCB master.
module ov5640_init_seq
    import ov5640_init_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 24,
    parameter int TABLE_LEN       = 252,
    parameter int PWRUP_DELAY_CYC = PWRUP_DELAY_50M,
    parameter int RST_DELAY_CYC   = RST_DELAY_50M,
    parameter int DELAY_INDEX     = 1,
    parameter int MAX_RETRY       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  sccb_req,
    output logic [15:0]           sccb_reg_addr,
    output logic [7:0]            sccb_wr_data,
    input  logic                  sccb_ready,
    input  logic                  sccb_done,
    input  logic                  sccb_nack,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_error,
    output logic [ADDR_WIDTH-1:0] wr_index
);

    localparam int DW = $clog2(max_int(PWRUP_DELAY_CYC, RST_DELAY_CYC)) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] index, index_n, rom_addr_n;
    logic [RW-1:0]         retry, retry_n, retry_inc;
    logic                  armed, armed_n, rw_second, rw_second_n;
    logic                  req_n, busy_n, done_n, error_n;
    logic [15:0]           reg_addr_n;
    logic [7:0]            wr_data_n;
    logic                  dly_start, dly_expire, last;
    logic [DW-1:0]         dly_load;

    ov5640_delay_cnt #(.WIDTH(DW)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .start  (dly_start),
        .load   (dly_load),
        .expire (dly_expire)
    );

    assign last      = (index == ADDR_WIDTH'(TABLE_LEN - 1));
    assign retry_inc = retry + 1'b1;
    assign wr_index  = index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PWRUP;
            index         <= '0;
            retry         <= '0;
            armed         <= 1'b0;
            rw_second     <= 1'b0;
            rom_addr      <= '0;
            sccb_req      <= 1'b0;
            sccb_reg_addr <= '0;
            sccb_wr_data  <= '0;
            init_busy     <= 1'b0;
            init_done     <= 1'b0;
            init_error    <= 1'b0;
        end else begin
            state         <= state_n;
            index         <= index_n;
            retry         <= retry_n;
            armed         <= armed_n;
            rw_second     <= rw_second_n;
            rom_addr      <= rom_addr_n;
            sccb_req      <= req_n;
            sccb_reg_addr <= reg_addr_n;
            sccb_wr_data  <= wr_data_n;
            init_busy     <= busy_n;
            init_done     <= done_n;
            init_error    <= error_n;
        end
    end

    always_comb begin
        state_n     = state;
        index_n     = index;
        retry_n     = retry;
        armed_n     = armed;
        rw_second_n = rw_second;
        rom_addr_n  = rom_addr;
        req_n       = sccb_req;
        reg_addr_n  = sccb_reg_addr;
        wr_data_n   = sccb_wr_data;
        busy_n      = init_busy;
        done_n      = init_done;
        error_n     = init_error;
        dly_start   = 1'b0;
        dly_load    = DW'(PWRUP_DELAY_CYC);
        case (state)
            PWRUP: begin
                busy_n = 1'b1;
                if (!armed) begin
                    dly_start = 1'b1;
                    armed_n   = 1'b1;
                end else if (dly_expire) begin
                    index_n = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                rom_addr_n  = index;
                rw_second_n = 1'b0;
                state_n     = ROMWAIT;
            end
            ROMWAIT: begin
                // ROM output is registered: usable on the second cycle
                if (!rw_second) begin
                    rw_second_n = 1'b1;
                end else begin
                    reg_addr_n = rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
                    wr_data_n  = rom_q[DATA_MSB:0];
                    req_n      = 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                if (sccb_req && sccb_ready) begin
                    req_n   = 1'b0;
                    state_n = WAITDONE;
                end
            end
            WAITDONE: begin
                if (sccb_done && !sccb_nack) begin
                    retry_n = '0;
                    if (index == ADDR_WIDTH'(DELAY_INDEX)) begin
                        dly_start = 1'b1;
                        dly_load  = DW'(RST_DELAY_CYC);
                        state_n   = DLY;
                    end else if (last) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        index_n = index + 1'b1;
                        state_n = FETCH;
                    end
                end else if (sccb_done) begin
                    retry_n = retry_inc;
                    if (32'(retry_inc) < MAX_RETRY) begin
                        req_n   = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = ERROR;
                        error_n = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            DLY: begin
                if (dly_expire) begin
                    if (last) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        index_n = index + 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            DONE, ERROR: begin
                if (init_start) begin
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    retry_n = '0;
                    index_n = '0;
                    busy_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = PWRUP;
        endcase
    end

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Bench for ov5640_init_seq: behavioural ROM, SCCB master model and write-sequence reference.
module tb_ov5640_init_seq;

    localparam int AW = 8;
    localparam int TL = 4;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_q = '0;
    logic          sccb_req;
    logic [15:0]   sccb_reg_addr;
    logic [7:0]    sccb_wr_data;
    logic          sccb_ready = 1'b1;
    logic          sccb_done = 1'b0;
    logic          sccb_nack = 1'b0;
    logic          init_busy, init_done, init_error;
    logic [AW-1:0] wr_index;

    ov5640_init_seq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(24), .TABLE_LEN(TL),
        .PWRUP_DELAY_CYC(10), .RST_DELAY_CYC(20),
        .DELAY_INDEX(1), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .init_start(init_start),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .sccb_req(sccb_req), .sccb_reg_addr(sccb_reg_addr),
        .sccb_wr_data(sccb_wr_data), .sccb_ready(sccb_ready),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .init_busy(init_busy), .init_done(init_done),
        .init_error(init_error), .wr_index(wr_index)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] rom_tab [TL];
    logic        nack_tab [TL][MR];

    always @(posedge clk) rom_q <= rom_tab[rom_addr[1:0]];

    // SCCB master: done (with nack from the table) 5 cycles after accept
    logic [23:0] log_w [$];
    int          log_i [$];
    int          log_c [$];
    int          done_c [$];
    int          cd;
    int          att [TL];
    logic        nack_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cd        <= 0;
            sccb_done <= 1'b0;
            sccb_nack <= 1'b0;
            nack_pend <= 1'b0;
            for (int k = 0; k < TL; k++) att[k] <= 0;
            log_w.delete();
            log_i.delete();
            log_c.delete();
            done_c.delete();
        end else begin
            sccb_done <= 1'b0;
            sccb_nack <= 1'b0;
            if (cd == 1) begin
                sccb_done <= 1'b1;
                sccb_nack <= nack_pend;
                done_c.push_back(cyc);
            end
            if (cd != 0) cd <= cd - 1;
            if (sccb_req && sccb_ready) begin
                log_w.push_back({sccb_reg_addr, sccb_wr_data});
                log_i.push_back(int'(wr_index));
                log_c.push_back(cyc);
                cd <= 5;
                nack_pend <= (att[wr_index[1:0]] < MR) ?
                             nack_tab[wr_index[1:0]][att[wr_index[1:0]]] : 1'b0;
                att[wr_index[1:0]] <= att[wr_index[1:0]] + 1;
            end
        end
    end

    // Reference: the write list implied by the table and the nack pattern
    logic [23:0] exp_w [$];
    int          exp_i [$];
    logic        exp_err;
    int          exp_fail;
    int          rel_cyc;

    function automatic void build_model();
        exp_w.delete();
        exp_i.delete();
        exp_err  = 1'b0;
        exp_fail = 0;
        for (int i = 0; i < TL && !exp_err; i++) begin
            for (int a = 0; a < MR; a++) begin
                exp_w.push_back(rom_tab[i]);
                exp_i.push_back(i);
                if (!nack_tab[i][a]) break;
                if (a == MR - 1) begin
                    exp_err  = 1'b1;
                    exp_fail = i;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_outputs",
              {rom_addr, sccb_req, sccb_reg_addr, sccb_wr_data,
               init_busy, init_done, init_error, wr_index}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(init_done || init_error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 2000), 64'd1);
    endtask

    task automatic compare_log(input string tag, input int base);
        int sz;
        sz = log_w.size() - base;
        check({tag, "_nwrites"}, 64'(sz), 64'(exp_w.size()));
        for (int k = 0; k < sz && k < exp_w.size(); k++) begin
            check({tag, "_word"}, 64'(log_w[base + k]), 64'(exp_w[k]));
            check({tag, "_idx"}, 64'(log_i[base + k]), 64'(exp_i[k]));
        end
    endtask

    task automatic clear_nacks();
        for (int i = 0; i < TL; i++)
            for (int a = 0; a < MR; a++) nack_tab[i][a] = 1'b0;
    endtask

    task automatic rand_rom();
        for (int i = 0; i < TL; i++) rom_tab[i] = 24'($urandom);
    endtask

    initial begin
        int n;
        int base;
        logic [23:0] held;
        logic stable;

        // Nominal table
        rom_tab[0] = 24'h310311;
        rom_tab[1] = 24'h300882;
        rom_tab[2] = 24'h300842;
        rom_tab[3] = 24'h310303;
        clear_nacks();
        build_model();
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        check("busy_after_release", 64'(init_busy), 64'd1);
        wait_end("nom");
        compare_log("nom", 0);
        if (log_c.size() >= 3 && done_c.size() >= 2) begin
            check("nom_pwrup_gap", 64'((log_c[0] - rel_cyc) >= 10), 64'd1);
            check("nom_rst_gap", 64'((log_c[2] - done_c[1]) >= 20), 64'd1);
        end
        check("nom_flags", {init_done, init_busy, init_error}, 64'b100);
        check("nom_wr_index", 64'(wr_index), 64'd3);

        // NACK on entry 2, first attempt only
        rand_rom();
        clear_nacks();
        nack_tab[2][0] = 1'b1;
        build_model();
        apply_reset();
        wait_end("nack1");
        compare_log("nack1", 0);
        check("nack1_flags", {init_done, init_error}, 64'b10);

        // NACK every attempt on entry 0
        rand_rom();
        clear_nacks();
        for (int a = 0; a < MR; a++) nack_tab[0][a] = 1'b1;
        build_model();
        apply_reset();
        wait_end("nackall");
        repeat (30) @(negedge clk);
        compare_log("nackall", 0);
        check("nackall_flags", {init_done, init_busy, init_error},
              {62'd0, exp_err});
        check("nackall_wr_index", 64'(wr_index), 64'(exp_fail));

        // Ready held low for 7 cycles while a request is pending
        rand_rom();
        clear_nacks();
        build_model();
        sccb_ready = 1'b0;
        apply_reset();
        n = 0;
        while (!sccb_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rdy_req_seen", 64'(n < 200), 64'd1);
        held = {sccb_reg_addr, sccb_wr_data};
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (!sccb_req || {sccb_reg_addr, sccb_wr_data} !== held)
                stable = 1'b0;
        end
        check("rdy_stable", 64'(stable), 64'd1);
        check("rdy_held_word", 64'(held), 64'(rom_tab[0]));
        sccb_ready = 1'b1;
        @(negedge clk);
        check("rdy_req_drop", 64'(sccb_req), 64'd0);
        check("rdy_accepts", 64'(log_w.size()), 64'd1);
        wait_end("rdy");
        compare_log("rdy", 0);

        // Reset while waiting for done of entry 2
        rand_rom();
        clear_nacks();
        build_model();
        apply_reset();
        n = 0;
        while (log_w.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_entry2", 64'(wr_index), 64'd2);
        @(negedge clk);
        apply_reset();
        wait_end("mid");
        compare_log("mid", 0);
        if (log_c.size() > 0)
            check("mid_pwrup_gap", 64'((log_c[0] - rel_cyc) >= 10), 64'd1);
        check("mid_done", 64'(init_done), 64'd1);

        // init_start ignored while busy, honoured in DONE
        rand_rom();
        clear_nacks();
        build_model();
        apply_reset();
        repeat (15) @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_end("start_busy");
        compare_log("start_busy", 0);
        base = log_w.size();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check("restart_flags", {init_done, init_busy, init_error}, 64'b010);
        check("restart_wr_index", 64'(wr_index), 64'd0);
        n = 0;
        while (!sccb_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("restart_fast_req", 64'(n <= 4), 64'd1);
        wait_end("restart");
        compare_log("restart", base);
        check("restart_done", 64'(init_done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
